// File: rtl/pulse_to_level_converter_if.sv
// Request/level bundle between a pulse producer and the pulse-to-level converter.
// The master drives pulse_in/ack/clr_miss; the slave (converter) returns the level and status.
interface pulse_to_level_converter_if #(
   parameter int MISS_W = 4
);
   // Handshake: a high pulse_in sample is one request. level_out then holds high until
   // ack is seen (after the minimum width) or the timeout expires, and is always
   // followed by at least one low cycle.
   logic              pulse_in;
   logic              ack;
   logic              clr_miss;
   logic              level_out;
   logic              busy;
   logic              timeout;
   logic [MISS_W-1:0] miss_count;
   logic [1:0]        state_dbg;

   modport master (
      output pulse_in, ack, clr_miss,
      input  level_out, busy, timeout, miss_count, state_dbg
   );

   modport slave (
      input  pulse_in, ack, clr_miss,
      output level_out, busy, timeout, miss_count, state_dbg
   );
endinterface

// File: rtl/pulse_to_level_converter.sv
// Stretches a one-cycle request into a level held until ack (after MIN_HIGH cycles) or
// TIMEOUT cycles, then one guaranteed low cycle. Requests arriving while high are counted.
module pulse_to_level_converter #(
   parameter int MIN_HIGH = 4,
   parameter int TIMEOUT  = 64,
   parameter int MISS_W   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   pulse_to_level_converter_if.slave    bus
);
   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_HIGH);
   localparam logic [CNT_W-1:0]  TO_C     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e              cs_q, cs_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ack_seen_q, ack_seen_d;
   logic                timeout_q, timeout_d;
   logic [MISS_W-1:0]   miss_q, miss_d;

   logic ack_any;
   logic at_timeout;
   logic exit_high;

   assign ack_any    = bus.ack | ack_seen_q;
   assign at_timeout = (cnt_q == TO_C);
   assign exit_high  = (ack_any && (cnt_q >= MIN_C)) || at_timeout;

   always_comb begin
      cs_d       = cs_q;
      cnt_d      = cnt_q;
      ack_seen_d = ack_seen_q;
      timeout_d  = 1'b0;
      case (cs_q)
         IDLE: begin
            if (bus.pulse_in) begin
               cs_d       = HIGH;
               cnt_d      = CNT_ONE;
               ack_seen_d = 1'b0;
            end
         end
         HIGH: begin
            ack_seen_d = ack_any;
            if (exit_high) begin
               cs_d      = GAP;
               // ack in the final cycle wins over the timeout
               timeout_d = at_timeout && !ack_any;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         GAP: begin
            if (bus.pulse_in) begin
               cs_d       = HIGH;
               cnt_d      = CNT_ONE;
               ack_seen_d = 1'b0;
            end else begin
               cs_d  = IDLE;
               cnt_d = '0;
            end
         end
         default: begin
            cs_d       = IDLE;
            cnt_d      = '0;
            ack_seen_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      miss_d = miss_q;
      if (bus.clr_miss) begin
         miss_d = '0;
      end else if ((cs_q == HIGH) && bus.pulse_in && (miss_q != MISS_MAX)) begin
         miss_d = miss_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_q       <= IDLE;
         cnt_q      <= '0;
         ack_seen_q <= 1'b0;
         timeout_q  <= 1'b0;
         miss_q     <= '0;
      end else begin
         cs_q       <= cs_d;
         cnt_q      <= cnt_d;
         ack_seen_q <= ack_seen_d;
         timeout_q  <= timeout_d;
         miss_q     <= miss_d;
      end
   end

   assign bus.level_out  = (cs_q == HIGH);
   assign bus.busy       = (cs_q != IDLE);
   assign bus.timeout    = timeout_q;
   assign bus.miss_count = miss_q;
   assign bus.state_dbg  = cs_q;
endmodule

// File: tb/tb_pulse_to_level_converter.sv
// Bench for pulse_to_level_converter: directed vector table, hand-written corner sequences,
// and random/loopback traffic against a cycle-counting reference model.
module tb_pulse_to_level_converter;
   logic clk;
   logic rst;
   logic drv_pulse, drv_ack, drv_clr, loop_mode;
   logic lvl0_q;
   logic l2p0;

   int n_cmp;
   int n_fail;

   pulse_to_level_converter_if #(.MISS_W(4)) bus0 ();
   pulse_to_level_converter_if #(.MISS_W(4)) bus1 ();

   pulse_to_level_converter #(.MIN_HIGH(4), .TIMEOUT(64), .MISS_W(4)) dut0 (
      .clk   (clk),
      .reset (rst),
      .bus   (bus0)
   );

   // Degenerate instance: MIN_HIGH=1, short timeout, ack tied to its own level in loopback.
   pulse_to_level_converter #(.MIN_HIGH(1), .TIMEOUT(3), .MISS_W(4)) dut1 (
      .clk   (clk),
      .reset (rst),
      .bus   (bus1)
   );

   // Far-side level-to-pulse converter: one pulse on each rising edge of level_out.
   always @(posedge clk or posedge rst) begin
      if (rst) lvl0_q <= 1'b0;
      else     lvl0_q <= bus0.level_out;
   end
   assign l2p0 = bus0.level_out & ~lvl0_q;

   assign bus0.pulse_in = drv_pulse;
   assign bus0.clr_miss = drv_clr;
   assign bus0.ack      = loop_mode ? l2p0 : drv_ack;
   assign bus1.pulse_in = drv_pulse;
   assign bus1.clr_miss = drv_clr;
   assign bus1.ack      = loop_mode ? bus1.level_out : drv_ack;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Tracks "how many cycles the level has been high" as a plain integer (0 = low),
   // whether the single low cycle after a level is in progress, and the request tallies.
   int min_h [2] = '{4, 1};
   int to_h  [2] = '{64, 3};
   int m_high[2], m_gap[2], m_acked[2], m_to[2], m_miss[2], m_missraw[2], m_accept[2];

   task automatic model_step(input int i, input bit p, input bit a, input bit c);
      bit acked;
      if (m_high[i] > 0) begin
         acked = (m_acked[i] != 0) || a;
         m_acked[i] = acked;
         if (p) begin
            m_missraw[i]++;
            if (m_miss[i] < 15) m_miss[i]++;
         end
         if ((acked && m_high[i] >= min_h[i]) || m_high[i] == to_h[i]) begin
            m_to[i]   = (m_high[i] == to_h[i]) && !acked;
            m_high[i] = 0;
            m_gap[i]  = 1;
         end else begin
            m_high[i]++;
            m_to[i] = 0;
         end
      end else begin
         m_to[i]  = 0;
         m_gap[i] = 0;
         if (p) begin
            m_high[i]  = 1;
            m_acked[i] = 0;
            m_accept[i]++;
         end
      end
      if (c) m_miss[i] = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_high[i] = 0; m_gap[i] = 0; m_acked[i] = 0; m_to[i] = 0;
            m_miss[i] = 0; m_missraw[i] = 0; m_accept[i] = 0;
         end
      end else begin
         model_step(0, drv_pulse, bus0.ack, drv_clr);
         model_step(1, drv_pulse, bus1.ack, drv_clr);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_models(input string tag);
      check({tag, "0.level"},   32'(bus0.level_out),  32'(m_high[0] > 0));
      check({tag, "0.busy"},    32'(bus0.busy),       32'(m_high[0] > 0 || m_gap[0] != 0));
      check({tag, "0.timeout"}, 32'(bus0.timeout),    32'(m_to[0]));
      check({tag, "0.miss"},    32'(bus0.miss_count), 32'(m_miss[0]));
      check({tag, "1.level"},   32'(bus1.level_out),  32'(m_high[1] > 0));
      check({tag, "1.busy"},    32'(bus1.busy),       32'(m_high[1] > 0 || m_gap[1] != 0));
      check({tag, "1.timeout"}, 32'(bus1.timeout),    32'(m_to[1]));
      check({tag, "1.miss"},    32'(bus1.miss_count), 32'(m_miss[1]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_timeout(input bit tie);
      int width;
      @(negedge clk);
      drv_pulse = 1'b1;
      @(negedge clk);
      drv_pulse = 1'b0;
      width = 0;
      while (bus0.level_out === 1'b1 && width < 200) begin
         width++;
         drv_ack = tie && (width == 64);
         @(negedge clk);
      end
      drv_ack = 1'b0;
      check(tie ? "tie.width" : "to.width", 32'(width), 32'd64);
      check(tie ? "tie.flag" : "to.flag", 32'(bus0.timeout), tie ? 32'd0 : 32'd1);
      check(tie ? "tie.gap_busy" : "to.gap_busy", 32'(bus0.busy), 32'd1);
      @(negedge clk);
      check(tie ? "tie.flag_clr" : "to.flag_clr", 32'(bus0.timeout), 32'd0);
      check(tie ? "tie.idle" : "to.idle", 32'(bus0.busy), 32'd0);
   endtask

   typedef struct {
      bit p, a, c;
      bit l, b, t;
      int m;
   } vec_t;

   vec_t vecs[26];
   int   n_pulses, n_l2p, cyc;

   initial begin
      // Directed table: inputs applied for one cycle, outputs checked just after the edge.
      vecs[0]  = '{1,0,0, 1,1,0,0};
      for (int k = 1; k <= 5; k++) vecs[k] = '{0,0,0, 1,1,0,0};
      vecs[6]  = '{0,1,0, 0,1,0,0};   // ack in high-cycle 6
      vecs[7]  = '{0,0,0, 0,0,0,0};
      vecs[8]  = '{1,0,0, 1,1,0,0};
      vecs[9]  = '{0,1,0, 1,1,0,0};   // early ack in high-cycle 1
      vecs[10] = '{0,0,0, 1,1,0,0};
      vecs[11] = '{0,0,0, 1,1,0,0};
      vecs[12] = '{0,0,0, 0,1,0,0};   // drops after exactly 4 high cycles
      vecs[13] = '{0,0,0, 0,0,0,0};
      vecs[14] = '{1,0,0, 1,1,0,0};
      vecs[15] = '{1,0,0, 1,1,0,1};   // missed
      vecs[16] = '{1,0,1, 1,1,0,0};   // clear beats increment
      vecs[17] = '{1,0,0, 1,1,0,1};
      vecs[18] = '{0,1,0, 0,1,0,1};
      vecs[19] = '{1,0,0, 1,1,0,1};   // pulse in GAP: back-to-back, not missed
      vecs[20] = '{0,1,0, 1,1,0,1};
      vecs[21] = '{0,0,0, 1,1,0,1};
      vecs[22] = '{0,0,0, 1,1,0,1};
      vecs[23] = '{0,0,0, 0,1,0,1};
      vecs[24] = '{0,0,0, 0,0,0,1};
      vecs[25] = '{0,0,1, 0,0,0,0};

      n_cmp = 0; n_fail = 0;
      drv_pulse = 1'b0; drv_ack = 1'b0; drv_clr = 1'b0; loop_mode = 1'b0;
      rst = 1'b1;
      #12;
      check("rst.level",   32'(bus0.level_out),  32'd0);
      check("rst.busy",    32'(bus0.busy),       32'd0);
      check("rst.timeout", 32'(bus0.timeout),    32'd0);
      check("rst.miss",    32'(bus0.miss_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 26; v++) begin
         @(negedge clk);
         drv_pulse = vecs[v].p; drv_ack = vecs[v].a; drv_clr = vecs[v].c;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d.level", v),   32'(bus0.level_out),  32'(vecs[v].l));
         check($sformatf("vec%0d.busy", v),    32'(bus0.busy),       32'(vecs[v].b));
         check($sformatf("vec%0d.timeout", v), 32'(bus0.timeout),    32'(vecs[v].t));
         check($sformatf("vec%0d.miss", v),    32'(bus0.miss_count), 32'(vecs[v].m));
      end
      @(negedge clk);
      drv_pulse = 1'b0; drv_ack = 1'b0; drv_clr = 1'b0;

      // Saturation: one accepted request followed by 20 missed ones.
      repeat (21) begin
         @(negedge clk);
         drv_pulse = 1'b1;
      end
      @(negedge clk);
      drv_pulse = 1'b0;
      check("sat.miss", 32'(bus0.miss_count), 32'd15);
      drv_ack = 1'b1;
      @(negedge clk);
      drv_ack = 1'b0;
      drv_clr = 1'b1;
      @(negedge clk);
      drv_clr = 1'b0;
      check("sat.clr", 32'(bus0.miss_count), 32'd0);
      repeat (3) @(negedge clk);

      run_timeout(1'b0);
      run_timeout(1'b1);

      // Reset in the middle of high-cycle 3 must clear outputs without a clock edge.
      @(negedge clk);
      drv_pulse = 1'b1;
      @(negedge clk);
      drv_pulse = 1'b0;
      repeat (2) @(negedge clk);
      check("mid.pre_level", 32'(bus0.level_out), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid.level", 32'(bus0.level_out), 32'd0);
      check("mid.busy",  32'(bus0.busy),      32'd0);
      check("mid.state", 32'(bus0.state_dbg), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drv_pulse = 1'b1;
      @(posedge clk);
      #1;
      check("mid.rise", 32'(bus0.level_out), 32'd1);
      @(negedge clk);
      drv_pulse = 1'b0;

      // Random traffic against the model.
      pulse_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         cmp_models("rnd");
         drv_pulse = ($urandom_range(0, 3) == 0);
         drv_ack   = ($urandom_range(0, 7) == 0);
         drv_clr   = ($urandom_range(0, 31) == 0);
      end
      @(negedge clk);
      drv_pulse = 1'b0; drv_ack = 1'b0; drv_clr = 1'b0;

      // Loopback: ack comes from the far-side pulse detector.
      loop_mode = 1'b1;
      pulse_reset();
      n_pulses = 0; n_l2p = 0; cyc = 0;
      while (n_pulses < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (l2p0) n_l2p++;
         cmp_models("lb");
         drv_pulse = ($urandom_range(0, 3) == 0);
         if (drv_pulse) n_pulses++;
      end
      @(negedge clk);
      drv_pulse = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (l2p0) n_l2p++;
         cmp_models("lb");
      end
      check("lb.pulses",   32'(n_pulses), 32'd1000);
      check("lb.accepted", 32'(n_l2p), 32'(m_accept[0]));
      check("lb.total",    32'(n_l2p + m_missraw[0]), 32'(n_pulses));
      loop_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
